// File: rtl/dmem_port_arbiter_if.sv
// dmem_port_arbiter_if: CPU, debug and data-memory signal bundle around the arbiter.
interface dmem_port_arbiter_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
);
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_done;
   logic              cpu_stall;
   logic              dbg_req;
   logic              dbg_we;
   logic [ADDR_W-1:0] dbg_addr;
   logic [DATA_W-1:0] dbg_wdata;
   logic              dbg_gnt;
   logic [DATA_W-1:0] dbg_rdata;
   logic              dbg_valid;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              busy;
   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_done, cpu_stall,
      input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
      output dbg_gnt, dbg_rdata, dbg_valid,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata,
      output busy
   );
   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_done, cpu_stall,
      output dbg_req, dbg_we, dbg_addr, dbg_wdata,
      input  dbg_gnt, dbg_rdata, dbg_valid,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata,
      input  busy
   );
endinterface

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one data-memory port between the CPU MEM stage and a debug port,
// CPU first with a starvation guard so DBG always makes progress.
module dmem_port_arbiter #(
   parameter int ADDR_W     = 64,
   parameter int DATA_W     = 64,
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 4
) (
   input logic clk,
   input logic reset,
   dmem_port_arbiter_if.slave bus
);
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] DONE   = 2'd2;
   localparam int LW = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [LW-1:0] LAT_INIT = LW'(MEM_LAT - 1);
   localparam logic [SW-1:0] S_MAX = SW'(STARVE_MAX);
   logic [1:0]        state;
   logic [LW-1:0]     lat_cnt;
   logic [SW-1:0]     starve_cnt;
   logic              own_dbg;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] cpu_rdata_q;
   logic [DATA_W-1:0] dbg_rdata_q;
   logic              idle;
   logic              sel_dbg;
   logic              sel_cpu;
   always_comb begin
      idle    = state == IDLE;
      sel_dbg = idle & bus.dbg_req & (~bus.cpu_req | starve_cnt == S_MAX);
      sel_cpu = idle & bus.cpu_req & ~sel_dbg;
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state       <= IDLE;
         lat_cnt     <= '0;
         starve_cnt  <= '0;
         own_dbg     <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         cpu_rdata_q <= '0;
         dbg_rdata_q <= '0;
      end else begin
         if (sel_dbg)
            starve_cnt <= '0;
         else if (sel_cpu & bus.dbg_req & starve_cnt != S_MAX)
            starve_cnt <= starve_cnt + 1'b1;
         case (state)
            IDLE:
               if (sel_dbg | sel_cpu) begin
                  state   <= ACCESS;
                  own_dbg <= sel_dbg;
                  we_q    <= sel_dbg ? bus.dbg_we : bus.cpu_we;
                  addr_q  <= sel_dbg ? bus.dbg_addr : bus.cpu_addr;
                  wdata_q <= sel_dbg ? bus.dbg_wdata : bus.cpu_wdata;
                  lat_cnt <= LAT_INIT;
               end
            ACCESS:
               if (lat_cnt == '0) begin
                  state <= DONE;
                  if (!we_q && own_dbg)
                     dbg_rdata_q <= bus.mem_rdata;
                  if (!we_q && !own_dbg)
                     cpu_rdata_q <= bus.mem_rdata;
               end else
                  lat_cnt <= lat_cnt - 1'b1;
            default: state <= IDLE;
         endcase
      end
   // All outputs decode from reset-cleared state, so an async reset drops them at once.
   assign bus.mem_en    = state == ACCESS;
   assign bus.mem_we    = bus.mem_en & we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.cpu_done  = (state == DONE) & ~own_dbg;
   assign bus.dbg_valid = (state == DONE) & own_dbg;
   assign bus.cpu_rdata = cpu_rdata_q;
   assign bus.dbg_rdata = dbg_rdata_q;
   assign bus.dbg_gnt   = sel_dbg & reset;
   assign bus.cpu_stall = bus.cpu_req & ~bus.cpu_done;
   assign bus.busy      = ~idle;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed checks of the data-memory arbiter at MEM_LAT=2 and MEM_LAT=1.
module tb_dmem_port_arbiter;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   n_assert = 0;
   int   n_fail = 0;
   dmem_port_arbiter_if bus ();
   dmem_port_arbiter_if bus1 ();
   dmem_port_arbiter #(.MEM_LAT(2)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
   dmem_port_arbiter #(.MEM_LAT(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   initial begin
      {bus.cpu_req, bus.cpu_we, bus.dbg_req, bus.dbg_we} = '0;
      {bus.cpu_addr, bus.cpu_wdata, bus.dbg_addr, bus.dbg_wdata, bus.mem_rdata} = '0;
      {bus1.cpu_req, bus1.cpu_we, bus1.dbg_req, bus1.dbg_we} = '0;
      {bus1.cpu_addr, bus1.cpu_wdata, bus1.dbg_addr, bus1.dbg_wdata, bus1.mem_rdata} = '0;
      tick();
      chk("rst_busy", bus.busy, 0);
      chk("rst_mem_en", bus.mem_en, 0);
      chk("rst_mem_we", bus.mem_we, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_cpu_done", bus.cpu_done, 0);
      chk("rst_dbg_valid", bus.dbg_valid, 0);
      chk("rst_cpu_rdata", bus.cpu_rdata, 0);
      chk("rst_busy1", bus1.busy, 0);
      tick();
      reset = 1'b1;
      tick();
      // CPU read 0x10 -> 0xAB
      bus.cpu_req = 1'b1; bus.cpu_addr = 64'h10; bus.mem_rdata = 64'hAB;
      #1;
      chk("t1_c0_stall", bus.cpu_stall, 1);
      chk("t1_c0_mem_en", bus.mem_en, 0);
      tick();
      chk("t1_c1_mem_en", bus.mem_en, 1);
      chk("t1_c1_addr", bus.mem_addr, 64'h10);
      chk("t1_c1_we", bus.mem_we, 0);
      chk("t1_c1_stall", bus.cpu_stall, 1);
      tick();
      chk("t1_c2_mem_en", bus.mem_en, 1);
      chk("t1_c2_stall", bus.cpu_stall, 1);
      tick();
      chk("t1_c3_done", bus.cpu_done, 1);
      chk("t1_c3_rdata", bus.cpu_rdata, 64'hAB);
      chk("t1_c3_stall", bus.cpu_stall, 0);
      chk("t1_c3_mem_en", bus.mem_en, 0);
      bus.cpu_req = 1'b0;
      tick();
      chk("t1_c4_busy", bus.busy, 0);
      chk("t1_c4_done", bus.cpu_done, 0);
      // DBG write 0x20/0x55 alone
      bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 64'h20; bus.dbg_wdata = 64'h55;
      #1;
      chk("t2_c0_gnt", bus.dbg_gnt, 1);
      chk("t2_c0_stall", bus.cpu_stall, 0);
      tick();
      chk("t2_c1_gnt", bus.dbg_gnt, 0);
      chk("t2_c1_we", bus.mem_we, 1);
      chk("t2_c1_addr", bus.mem_addr, 64'h20);
      chk("t2_c1_wdata", bus.mem_wdata, 64'h55);
      tick();
      chk("t2_c2_we", bus.mem_we, 1);
      tick();
      chk("t2_c3_valid", bus.dbg_valid, 1);
      chk("t2_c3_mem_we", bus.mem_we, 0);
      chk("t2_c3_dbg_rdata", bus.dbg_rdata, 0);
      chk("t2_c3_cpu_rdata", bus.cpu_rdata, 64'hAB);
      chk("t2_c3_stall", bus.cpu_stall, 0);
      bus.dbg_req = 1'b0; bus.dbg_we = 1'b0;
      tick();
      chk("t2_c4_busy", bus.busy, 0);
      // both held: C,C,C,C,D,C,C,C,C,D
      bus.cpu_req = 1'b1; bus.cpu_addr = 64'h100;
      bus.dbg_req = 1'b1; bus.dbg_addr = 64'h200;
      for (int i = 0; i < 10; i++) begin
         #1;
         chk($sformatf("t3_gnt%0d", i), bus.dbg_gnt, (i == 4 || i == 9));
         tick();
         chk($sformatf("t3_addr%0d", i), bus.mem_addr, (i == 4 || i == 9) ? 64'h200 : 64'h100);
         tick();
         tick();
         chk($sformatf("t3_valid%0d", i), bus.dbg_valid, (i == 4 || i == 9));
         if (i == 9) begin
            bus.cpu_req = 1'b0; bus.dbg_req = 1'b0;
         end
         tick();
      end
      chk("t3_end_busy", bus.busy, 0);
      // reset during a CPU write access
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 64'h30; bus.cpu_wdata = 64'h77;
      tick();
      chk("t4_c1_we", bus.mem_we, 1);
      #2;
      reset = 1'b0;
      #1;
      chk("t4_rst_we", bus.mem_we, 0);
      chk("t4_rst_en", bus.mem_en, 0);
      chk("t4_rst_busy", bus.busy, 0);
      tick();
      chk("t4_rst_done", bus.cpu_done, 0);
      tick();
      chk("t4_rst_done2", bus.cpu_done, 0);
      bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
      reset = 1'b1;
      tick();
      bus.cpu_req = 1'b1; bus.cpu_addr = 64'h40; bus.mem_rdata = 64'h99;
      tick();
      chk("t4_new_addr", bus.mem_addr, 64'h40);
      tick();
      tick();
      chk("t4_new_done", bus.cpu_done, 1);
      chk("t4_new_rdata", bus.cpu_rdata, 64'h99);
      bus.cpu_req = 1'b0;
      tick();
      // CPU drops request right after selection
      bus.cpu_req = 1'b1; bus.cpu_addr = 64'h50; bus.mem_rdata = 64'h5A;
      tick();
      bus.cpu_req = 1'b0;
      chk("t5_c1_en", bus.mem_en, 1);
      tick();
      chk("t5_c2_en", bus.mem_en, 1);
      tick();
      chk("t5_c3_done", bus.cpu_done, 1);
      chk("t5_c3_rdata", bus.cpu_rdata, 64'h5A);
      chk("t5_c3_en", bus.mem_en, 0);
      tick();
      chk("t5_c4_busy", bus.busy, 0);
      tick();
      chk("t5_c5_en", bus.mem_en, 0);
      chk("t5_c5_busy", bus.busy, 0);
      // MEM_LAT=1 DBG read 0x8
      bus1.dbg_req = 1'b1; bus1.dbg_addr = 64'h8; bus1.mem_rdata = 64'h11;
      #1;
      chk("t6_c0_gnt", bus1.dbg_gnt, 1);
      tick();
      bus1.mem_rdata = 64'hC3;
      chk("t6_c1_en", bus1.mem_en, 1);
      chk("t6_c1_addr", bus1.mem_addr, 64'h8);
      tick();
      bus1.mem_rdata = 64'hEE;
      bus1.dbg_req = 1'b0;
      #1;
      chk("t6_c2_valid", bus1.dbg_valid, 1);
      chk("t6_c2_en", bus1.mem_en, 0);
      chk("t6_c2_rdata", bus1.dbg_rdata, 64'hC3);
      tick();
      chk("t6_c3_busy", bus1.busy, 0);
      chk("t6_c3_valid", bus1.dbg_valid, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
